// File: rtl/aes_pkg.sv
// Shared types and constants for the iterative AES-128 encryption controller.
package aes_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INIT_KEY = 2'd1,
    ROUND    = 2'd2,
    DONE     = 2'd3
  } ctrl_state_t;

  localparam int         AES_BLK_W     = 128;
  localparam int         AES128_ROUNDS = 10;
  localparam logic [3:0] FINAL_ROUND   = 4'd9;
endpackage

// File: rtl/aes_round_counter.sv
// Round counter: synchronous clear, enable-gated increment that wraps after
// rollover_val, and a flag marking the last round.
module aes_round_counter
  import aes_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [CNT_W-1:0] rollover_val,
  output logic [CNT_W-1:0] count,
  output logic             last_round
);

  assign last_round = (count == rollover_val);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (count_enable) begin
      count <= last_round ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 sequencer: owns the block state, fetches round keys and
// steps the shared single-round datapath once per round.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter int CNT_W      = 4,
  parameter int BLK_W      = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  output logic             rk_req,
  output logic [CNT_W-1:0] rk_idx,
  input  logic             rk_valid,
  input  logic [BLK_W-1:0] rk_data,
  output logic [BLK_W-1:0] dp_state,
  output logic [BLK_W-1:0] dp_key,
  input  logic [BLK_W-1:0] dp_result,
  output logic [CNT_W-1:0] count_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             busy,
  output logic [15:0]      blocks_done
);

  if (NUM_ROUNDS != AES128_ROUNDS) begin : g_bad_rounds
    $error("aes_round_ctrl supports only AES-128 (NUM_ROUNDS = 10)");
  end

  ctrl_state_t      st_q, st_d;
  logic [BLK_W-1:0] state_q;
  logic [15:0]      blk_cnt;
  logic             cnt_clear, cnt_en, last_round;

  aes_round_counter #(.CNT_W(CNT_W)) u_round_cnt (
    .clk          (clk),
    .rst          (rst),
    .clear        (cnt_clear),
    .count_enable (cnt_en),
    .rollover_val (CNT_W'(NUM_ROUNDS - 1)),
    .count        (count_out),
    .last_round   (last_round)
  );

  always_ff @(posedge clk) begin
    if (rst) st_q <= IDLE;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d      = st_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    unique case (st_q)
      IDLE:     if (in_valid) st_d = INIT_KEY;
      INIT_KEY: if (rk_valid) begin
                  st_d      = ROUND;
                  cnt_clear = 1'b1;
                end
      ROUND:    if (rk_valid) begin
                  if (last_round) st_d   = DONE;
                  else            cnt_en = 1'b1;
                end
      DONE:     if (out_ready) begin
                  st_d      = IDLE;
                  cnt_clear = 1'b1;
                end
      default:  st_d = IDLE;
    endcase
  end

  // Handshake outputs depend on the state register only, never on inputs.
  assign in_ready  = (st_q == IDLE);
  assign rk_req    = (st_q == INIT_KEY) || (st_q == ROUND);
  assign rk_idx    = (st_q == ROUND) ? count_out + CNT_W'(1) : '0;
  assign out_valid = (st_q == DONE);
  assign busy      = (st_q != IDLE);

  assign dp_state    = state_q;
  assign dp_key      = rk_data;
  assign out_data    = state_q;
  assign blocks_done = blk_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
    end else begin
      unique case (st_q)
        IDLE:     if (in_valid) state_q <= in_data;
        INIT_KEY: if (rk_valid) state_q <= state_q ^ rk_data;
        ROUND:    if (rk_valid) state_q <= dp_result;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt <= '0;
    end else if ((st_q == DONE) && out_ready) begin
      blk_cnt <= blk_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: emulates the round datapath and key schedule with a
// behavioural AES model and checks ciphertext, timing and counters.
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, rk_req, out_valid, out_ready, busy;
  logic         rk_valid = 1'b0;
  logic [127:0] in_data, rk_data, dp_state, dp_key, dp_result, out_data;
  logic [3:0]   rk_idx, count_out;
  logic [15:0]  blocks_done;

  int           n_checks = 0;
  int           n_errors = 0;
  int unsigned  cyc = 0;
  int           kmode = 0;
  int           scnt = 0;
  logic [127:0] rk_tbl [0:15];
  logic [15:0]  exp_blocks;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_round_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rk_req(rk_req), .rk_idx(rk_idx), .rk_valid(rk_valid), .rk_data(rk_data),
    .dp_state(dp_state), .dp_key(dp_key), .dp_result(dp_result),
    .count_out(count_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .blocks_done(blocks_done)
  );

  // ---------------- behavioural AES model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv, base, r, s;
    logic [7:0] e;
    inv = 8'h01; base = x; e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[0]) inv = gmul(inv, base);
      base = gmul(base, base);
      e = {1'b0, e[7:1]};
    end
    s = inv; r = inv;
    for (int i = 0; i < 4; i++) begin
      r = {r[6:0], r[7]};
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] key,
                                             input logic final_rnd);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   m [16];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = sbox(st[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
    for (int c = 0; c < 4; c++) begin
      if (final_rnd) begin
        for (int r = 0; r < 4; r++) m[r+4*c] = t[r+4*c];
      end else begin
        m[4*c]   = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
        m[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
        m[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
        m[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
      end
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = m[i] ^ key[127-8*i -: 8];
    return res;
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tw;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tw = w[i-1];
      if (i % 4 == 0) begin
        tw = {sbox(tw[23:16]) ^ rcon, sbox(tw[15:8]), sbox(tw[7:0]), sbox(tw[31:24])};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ tw;
    end
    for (int r = 0; r < 11; r++) rk_tbl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt);
    logic [127:0] st;
    st = pt ^ rk_tbl[0];
    for (int r = 1; r <= 10; r++) st = aes_round(st, rk_tbl[r], r == 10);
    return st;
  endfunction

  // ---------------- environment: datapath and key source ----------------
  assign dp_result = aes_round(dp_state, dp_key, count_out == 4'd9);
  assign rk_data   = rk_tbl[rk_idx];

  // kmode 0: rk_valid tied high; 1: three idle cycles before every key; 2: random.
  always @(negedge clk) begin
    case (kmode)
      1: begin
        if (rk_req && scnt == 3) begin rk_valid = 1'b1; scnt = 0; end
        else if (rk_req)         begin rk_valid = 1'b0; scnt = scnt + 1; end
        else                     begin rk_valid = 1'b0; scnt = 0; end
      end
      2:       rk_valid = ($urandom_range(0, 1) == 1);
      default: rk_valid = 1'b1;
    endcase
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_block(input logic [127:0] pt, input int bp, input bit nxt_v,
                           input logic [127:0] nxt_pt, input int exp_lat,
                           output logic [127:0] ct, output int unsigned acc_cyc);
    logic [127:0] exp_ct, prev_st;
    logic [3:0]   prev_cnt;
    bit           prev_round;
    int           lat, waited;
    exp_ct   = ref_encrypt(pt);
    in_valid = 1'b1;
    in_data  = pt;
    waited   = 0;
    while (!in_ready && waited < 100) begin @(posedge clk); #1; waited++; end
    chk("accept_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = nxt_v;
    in_data  = nxt_v ? nxt_pt : '0;
    chk("busy_after_accept", 128'(busy), 128'(1));
    chk("ready_after_accept", 128'(in_ready), 128'(0));
    chk("captured_block", dp_state, pt);
    lat = 1; prev_round = 1'b0; prev_cnt = count_out; prev_st = dp_state;
    while (!out_valid && lat < 600) begin
      @(posedge clk); #1;
      lat++;
      if (prev_round && !rk_valid) begin
        chk("stall_count", 128'(count_out), 128'(prev_cnt));
        chk("stall_state", dp_state, prev_st);
      end
      if (kmode == 0 && rk_idx != 4'd0) chk("count_step", 128'(count_out), 128'(lat - 2));
      prev_round = rk_req && (rk_idx != 4'd0);
      prev_cnt   = count_out;
      prev_st    = dp_state;
    end
    chk("out_valid_seen", 128'(out_valid), 128'(1));
    if (exp_lat > 0) chk("latency", 128'(lat), 128'(exp_lat));
    chk("ciphertext", out_data, exp_ct);
    chk("final_count", 128'(count_out), 128'(9));
    ct = out_data;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 128'(out_valid), 128'(1));
      chk("bp_data", out_data, exp_ct);
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      chk("bp_blocks", 128'(blocks_done), 128'(exp_blocks));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready  = 1'b0;
    exp_blocks = exp_blocks + 16'd1;
    chk("blocks_done", 128'(blocks_done), 128'(exp_blocks));
    chk("out_valid_clr", 128'(out_valid), 128'(0));
    chk("count_clr", 128'(count_out), 128'(0));
    chk("idle_ready", 128'(in_ready), 128'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ct, pa, pb;
    int unsigned  acc_a, acc_b;
    int           waited;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; kmode = 0;
    for (int i = 0; i < 16; i++) rk_tbl[i] = '0;
    expand_key(FIPS_KEY);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_blocks = 16'd0;

    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_rk_req", 128'(rk_req), 128'(0));
    chk("rst_rk_idx", 128'(rk_idx), 128'(0));
    chk("rst_count", 128'(count_out), 128'(0));
    chk("rst_blocks", 128'(blocks_done), 128'(0));
    chk("rst_state", out_data, 128'(0));

    run_block(FIPS_PT, 0, 1'b0, '0, 12, ct, acc_a);
    chk("fips_ct", ct, FIPS_CT);

    kmode = 1;
    run_block(FIPS_PT, 0, 1'b0, '0, 45, ct, acc_a);
    chk("stall_fips_ct", ct, FIPS_CT);
    kmode = 0;

    pa = rnd128(); pb = rnd128();
    run_block(pa, 5, 1'b1, pb, 12, ct, acc_a);
    run_block(pb, 0, 1'b0, '0, 12, ct, acc_b);

    pa = rnd128(); pb = rnd128();
    run_block(pa, 0, 1'b1, pb, 12, ct, acc_a);
    run_block(pb, 0, 1'b0, '0, 12, ct, acc_b);
    chk("b2b_spacing", 128'(acc_b - acc_a), 128'(13));

    // Abort a block mid-round with reset.
    in_valid = 1'b1; in_data = rnd128();
    @(posedge clk); #1;
    in_valid = 1'b0;
    waited = 0;
    while (!(rk_req && count_out == 4'd5) && waited < 50) begin @(posedge clk); #1; waited++; end
    chk("mid_round_reached", 128'(count_out), 128'(5));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_blocks = 16'd0;
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_count", 128'(count_out), 128'(0));
    chk("midrst_rk_req", 128'(rk_req), 128'(0));
    chk("midrst_blocks", 128'(blocks_done), 128'(0));
    chk("midrst_state", dp_state, 128'(0));
    run_block(rnd128(), 0, 1'b0, '0, 12, ct, acc_a);

    for (int i = 0; i < 6; i++) begin
      expand_key(rnd128());
      kmode = (i % 2 == 1) ? 2 : 0;
      run_block(rnd128(), $urandom_range(0, 3), 1'b0, '0, (kmode == 2) ? -1 : 12, ct, acc_a);
    end
    kmode = 0;

    force dut.blk_cnt = 16'hffff;
    @(posedge clk); #1;
    release dut.blk_cnt;
    exp_blocks = 16'hffff;
    chk("preload_blocks", 128'(blocks_done), 128'(16'hffff));
    run_block(rnd128(), 0, 1'b0, '0, 12, ct, acc_a);
    chk("wrap_blocks", 128'(blocks_done), 128'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Iterative AES-128 encryption sequencer. It owns the 128-bit state register and drives the shared single-round datapath (sub_bytes -> shift_rows -> mix columns -> add_round_key) once per round, supplying the round number that the mix-columns stage uses to bypass itself in the final round. It fetches round keys from the key-schedule block over a req/valid handshake and exchanges whole blocks with the SD-card buffer logic over valid/ready interfaces.

Parameters:
NUM_ROUNDS, 10, number of main rounds; only 10 (AES-128) is supported.
CNT_W, 4, width of count_out and rk_idx.
BLK_W, 128, AES block width.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  plaintext block offered
in_ready  output  1  controller can accept a block
in_data  input  128  plaintext block
rk_req  output  1  round-key request
rk_idx  output  4  requested round-key index, 0..10
rk_valid  input  1  rk_data valid for rk_idx
rk_data  input  128  round key
dp_state  output  128  current state to the round datapath
dp_key  output  128  round key to the datapath (rk_data passed through)
dp_result  input  128  combinational round result from the datapath
count_out  output  4  current round number, 0..9; 9 selects the no-mix-columns final round
out_valid  output  1  ciphertext valid
out_ready  input  1  downstream accepts ciphertext
out_data  output  128  ciphertext (equals the state register)
busy  output  1  high in every state except IDLE
blocks_done  output  16  count of blocks delivered; wraps 0xFFFF -> 0

Behaviour:
- States: IDLE, INIT_KEY, ROUND, DONE.
- Reset: state=IDLE, state reg=0, count_out=0, out_valid=0, rk_req=0, rk_idx=0, busy=0, blocks_done=0. in_ready=1 after reset because it is decoded from IDLE.
- IDLE: in_ready=1. When in_valid && in_ready, capture in_data into the state register and go to INIT_KEY.
- INIT_KEY: rk_req=1, rk_idx=0. In the cycle where rk_valid=1, state <= state ^ rk_data, count_out <= 0, and go to ROUND. Otherwise hold.
- ROUND: rk_req=1, rk_idx=count_out+1, dp_state=state register, dp_key=rk_data. In the cycle where rk_valid=1, state <= dp_result.
  - If count_out==NUM_ROUNDS-1, go to DONE and hold count_out at 9.
  - Otherwise count_out <= count_out+1.
  - While rk_valid=0: hold the state register and count_out; no datapath result is captured.
- DONE: out_valid=1, out_data=state register, held stable until out_ready. On out_valid && out_ready: blocks_done++, count_out <= 0, and go to IDLE.
- in_ready is 0 in DONE, so the minimum spacing between accepts is 13 cycles.
- Latency with rk_valid tied high: accept edge at T, INIT_KEY complete at T+1, rounds complete T+2..T+11, out_valid high from the cycle after T+11 (12 cycles after accept).
- rk_req, rk_idx, in_ready, out_valid and busy are decoded from the state register only, never from inputs, so there is no combinational input->output path.
- rk_valid while rk_req=0 is ignored. in_valid outside IDLE is ignored and the block is not consumed.
- count_out never exceeds 9. dp_state is driven in all states, but dp_result is sampled only in ROUND with rk_valid.
- rst asserted in any state, including mid-round or in DONE with out_valid high, returns to the reset values on the next edge. The partial block is discarded and not counted.
- blocks_done is a 16-bit unsigned counter with natural wrap.

Decomposition:
- aes_pkg holds:
  - ctrl_state_t enum {IDLE, INIT_KEY, ROUND, DONE};
  - localparams AES_BLK_W=128, AES128_ROUNDS=10, FINAL_ROUND=4'd9.
- One sub-module, aes_round_counter: a CNT_W-bit counter with clear, count_enable and rollover_val inputs and a last_round flag. It is instantiated for count_out. blocks_done is a plain register.

Test Plan:
- FIPS-197 C.1 vector: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, rk_valid tied high. Required: out_data=69c4e0d86a7b0430d8cdb78070b4c55a exactly 12 cycles after accept; count_out steps 0..9; blocks_done=1.
- Key stalls: rk_valid deasserted 3 cycles before every key. Required: same ciphertext, latency 12+33=45 cycles, and state/count_out frozen during each stall.
- Output backpressure: out_ready low 5 cycles in DONE. Required: out_valid and out_data stable, in_ready=0, second in_valid not consumed, blocks_done increments only on the handshake.
- Back-to-back blocks: two vectors, in_valid held high, out_ready=1. Required: both ciphertexts correct, accepts 13 cycles apart, blocks_done=2.
- Reset while count_out=5. Required: next cycle IDLE, in_ready=1, out_valid=0, count_out=0, blocks_done unchanged from its reset value 0; a new block then encrypts correctly.
- Wrap: preload blocks_done to 0xFFFF via 65535 forced transactions or a backdoor force, then complete one block. Required: blocks_done=0x0000.
